// File: rtl/sram_controller.sv
// Purpose: bridges one 32-bit memory-stage access onto two 16-bit SRAM accesses (low half, then high half).
// Latency: 2*ACCESS_CYCLES+2 cycles per access; rdata is valid in the DONE cycle.
// Backpressure: ready drops combinationally when a request appears and returns high only in DONE.
module sram_controller #(
    parameter int unsigned DATA_BASE     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef struct packed {
        logic        wr;
        logic [16:0] word;
        logic [31:0] dat;
    } req_t;

    req_t        req_q;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] eff;
    logic        last;
    logic        busy;
    logic        drive;

    // Only bits [18:2] survive: misaligned offsets are dropped and the space wraps at 2^19 bytes.
    assign eff   = address - 32'(DATA_BASE);
    assign last  = (cnt == 4'(ACCESS_CYCLES - 1));
    assign busy  = (state == S_LO) || (state == S_HI);
    assign drive = busy && req_q.wr;

    assign SRAM_ADDR = {req_q.word, state == S_HI};
    assign SRAM_DQ   = drive ? ((state == S_HI) ? req_q.dat[31:16] : req_q.dat[15:0]) : 16'bz;
    assign SRAM_WE_N = ~drive;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign ready = ((state == S_IDLE) && !wr_en && !rd_en) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            req_q <= '0;
            rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en || rd_en) begin
                        req_q.wr   <= wr_en;
                        req_q.word <= eff[18:2];
                        req_q.dat  <= wdata;
                        cnt        <= '0;
                        state      <= S_LO;
                    end
                end
                S_LO: begin
                    if (last) begin
                        if (!req_q.wr) begin
                            rdata[15:0] <= SRAM_DQ;
                        end
                        cnt   <= '0;
                        state <= S_HI;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HI: begin
                    if (last) begin
                        if (!req_q.wr) begin
                            rdata[31:16] <= SRAM_DQ;
                        end
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                // A request still asserted here is the one just served.
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: word-level reference memory, halfword SRAM model on the bus,
// directed scenarios followed by randomized back-to-back and gapped accesses.
module tb_sram_controller;

    localparam int N    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

    sram_controller #(.DATA_BASE(BASE), .ACCESS_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
        .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // Halfword SRAM chip model
    logic [15:0] sram [0:262143];
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'bz;
    always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { bit rd; logic [31:0] exp; } done_t;
    typedef struct { logic [17:0] a; logic [15:0] d; } wbeat_t;
    done_t       done_q[$];
    wbeat_t      wq[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;
    bit          mon_en = 1'b0;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] e;
        e = a - BASE;
        return int'((e >> 2) & 32'h1FFFF);
    endfunction

    task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int k;
        k = word_of(a);
        if (w) begin
            ref_mem[k] = d;
            wq.push_back('{a: 18'(k * 2),     d: d[15:0]});
            wq.push_back('{a: 18'(k * 2 + 1), d: d[31:16]});
            done_q.push_back('{rd: 1'b0, exp: last_rd});
        end else begin
            last_rd = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
            done_q.push_back('{rd: 1'b1, exp: last_rd});
        end
        wr_en   = w;
        rd_en   = r;
        address = a;
        wdata   = d;
    endtask

    // Issue one access, hold it until DONE, then drop it for `gap` cycles (0 = next request follows at once).
    task automatic run_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input int gap);
        int t;
        issue(w, r, a, d);
        t = 0;
        @(negedge clk);
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: no DONE after %0d cycles, expected %0d", t, 2 * N + 1);
        end
        @(posedge clk);
        #1;
        if (gap > 0) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Monitor: checks every SRAM write beat and every DONE cycle against the queues.
    int    run  = 0;
    int    wcnt = 0;
    done_t dq;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!SRAM_WE_N) begin
                if (wq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_we: addr %h, expected no write", SRAM_ADDR);
                end else begin
                    check("wr_addr", 32'(SRAM_ADDR), 32'(wq[0].a));
                    check("wr_data", 32'(SRAM_DQ), 32'(wq[0].d));
                    wcnt++;
                    if (wcnt == N) begin
                        void'(wq.pop_front());
                        wcnt = 0;
                    end
                end
            end
            if (!ready) begin
                run++;
            end else begin
                if (run > 0) begin
                    check("busy_cycles", run, 2 * N + 1);
                    if (done_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: rdata %h, expected no completion", rdata);
                    end else begin
                        dq = done_q.pop_front();
                        check(dq.rd ? "rd_data" : "rdata_hold", rdata, dq.exp);
                    end
                end
                run = 0;
            end
        end else begin
            run  = 0;
            wcnt = 0;
        end
    end

    initial begin
        logic [31:0] a;
        bit w, r;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_we_n", 32'(SRAM_WE_N), 1);
        check("rst_addr", 32'(SRAM_ADDR), 0);
        check("rst_rdata", rdata, 0);
        rd_en = 1'b1;
        #1;
        check("rst_ready_req", 32'(ready), 0);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Write then read
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1);
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 1);

        // Idle
        repeat (10) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 1);
            check("idle_we_n", 32'(SRAM_WE_N), 1);
            check("idle_rdata", rdata, last_rd);
        end
        @(posedge clk);
        #1;

        // Mapping, misalignment and wrap
        run_op(1'b1, 1'b0, 32'(BASE + 8 + 3), $urandom, 1);
        run_op(1'b1, 1'b0, 32'(BASE + (1 << 19)), 32'hCAFEF00D, 1);

        // Simultaneous rd_en/wr_en is a write
        run_op(1'b1, 1'b1, 32'd1028, 32'h12345678, 0);
        run_op(1'b0, 1'b1, 32'd1028, 32'h0, 1);

        // Back-to-back reads held continuously
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 0);
        run_op(1'b0, 1'b1, 32'd1032, 32'h0, 1);

        // Reset during the first HI cycle of a write
        mon_en  = 1'b0;
        wr_en   = 1'b1;
        address = 32'(BASE + 64);
        wdata   = $urandom;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_we_n", 32'(SRAM_WE_N), 1);
        check("midrst_rdata", rdata, 0);
        check("midrst_ready", 32'(ready), 1);
        last_rd = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_op(1'b0, 1'b1, 32'd1024, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a = 32'(BASE) + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'(1 << 19);
            run_op(w, r, a, $urandom, $urandom_range(0, 2));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        check("wq_empty", 32'(wq.size()), 0);
        check("done_q_empty", 32'(done_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
